// File: rtl/mul_seq_unit_pkg.sv
// Shared types and constants for the sequential shift-add multiplier and its
// register-file writeback (hi half -> DX, lo half -> AX).
package mul_seq_unit_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    localparam logic [2:0] REG_AX = 3'd0;
    localparam logic [2:0] REG_DX = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_datapath.sv
// Operand magnitude/sign capture, one-bit-per-cycle shift-add accumulator and
// the final two's-complement fixup into the registered product.
module mul_datapath
    import mul_seq_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             finish_i,
    input  logic             signed_op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] prod_lo_o,
    output logic [WIDTH-1:0] prod_hi_o
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_step, mplier_step;
    logic [2*WIDTH-1:0] p_step;

    always_comb begin
        a_mag       = (signed_op_i && op_a_i[WIDTH-1]) ? -op_a_i : op_a_i;
        b_mag       = (signed_op_i && op_b_i[WIDTH-1]) ? -op_b_i : op_b_i;
        // Carry of the add lands in the top accumulator bit after the shift.
        sum         = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_step    = sum[WIDTH:1];
        mplier_step = {sum[0], mplier_q[WIDTH-1:1]};
        p_step      = {acc_step, mplier_step};

        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        prod_d   = prod_q;

        if (load_i) begin
            mcand_d  = a_mag;
            mplier_d = b_mag;
            acc_d    = '0;
            neg_d    = signed_op_i & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
        end else if (step_i) begin
            acc_d    = acc_step;
            mplier_d = mplier_step;
        end

        // Product is taken from the last iteration's result on the same edge.
        if (finish_i) begin
            prod_d = neg_q ? -p_step : p_step;
        end
    end

    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        acc_q    <= acc_d;
        mplier_q <= mplier_d;
        neg_q    <= neg_d;
        if (rst) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    assign prod_lo_o = prod_q[WIDTH-1:0];
    assign prod_hi_o = prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential 32x32 multiplier: FSM, iteration counter and start/busy/done
// handshake, plus the one-cycle regfile writeback strobes.
module mul_seq_unit
    import mul_seq_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi,
    output logic             wb_sto,
    output logic             wb_mul
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, step, finish;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Back-to-back issue; a flush here cannot cancel the writeback.
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mul_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .step_i     (step),
        .finish_i   (finish),
        .signed_op_i(signed_op),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .prod_lo_o  (prod_lo),
        .prod_hi_o  (prod_hi)
    );

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign wb_sto = done;
    assign wb_mul = done;

endmodule

// File: doc/mul_seq_unit.md
Name: mul_seq_unit

Overview:
- Iterative shift-add 32x32 multiplier in the execute stage, directly upstream of the 8x32 register file's write port.
- Produces a 64-bit product plus a one-cycle writeback strobe pair (sto/mul) that routes hi to DX (reg 3) and lo to AX (reg 0).
- Supports unsigned and signed operands; one bit per cycle; start/busy/done handshake toward the control unit.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH; iteration count = WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE or DONE
signed_op  input  1  1 = two's-complement operands; sampled with start
flush  input  1  synchronous abort of an in-flight operation (pipeline kill)
op_a  input  WIDTH  multiplicand, sampled with start
op_b  input  WIDTH  multiplier, sampled with start
busy  output  1  high while state = RUN
done  output  1  one-cycle pulse, high in DONE
prod_lo  output  WIDTH  low half of product (registered)
prod_hi  output  WIDTH  high half of product (registered)
wb_sto  output  1  register-file write strobe, equals done
wb_mul  output  1  register-file mul-select, equals done

Behaviour:
- Reset (rst=1 at an edge): state IDLE, counter 0, busy 0, done 0, wb_sto 0, wb_mul 0, prod_lo 0, prod_hi 0. rst has priority over flush and start; reset mid-RUN discards the operation and produces no writeback.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> load |op_a| and |op_b| (magnitudes only when signed_op=1, else raw), neg = signed_op & (a[msb] ^ b[msb]), accumulator 0, counter 0 -> RUN.
- RUN: each cycle, if multiplier LSB = 1, add multiplicand to the upper accumulator half (WIDTH+1-bit sum, carry kept). Shift the {carry, acc, multiplier} register right by 1. Counter increments.
- After the WIDTH-th iteration -> DONE. On that edge, prod_{hi,lo} <= neg ? -P : P (2*WIDTH-bit two's-complement negate).
- DONE: done = wb_sto = wb_mul = 1 for exactly one cycle.
  - start=1 in DONE is accepted (back-to-back) -> RUN with the new operands.
  - Otherwise -> IDLE.
- Latency: start high in cycle 0 -> done high in cycle WIDTH+1 (33 at default); throughput one op per WIDTH+1 cycles.
- start while busy: ignored, no queueing.
- flush=1 in RUN -> IDLE next cycle. No done, no writeback. prod_lo/prod_hi retain their previous values.
- flush in IDLE/DONE has no effect, and the DONE writeback still occurs. flush and start in the same IDLE cycle: flush wins, start is ignored.
- prod_lo/prod_hi hold their value until the next DONE entry or reset.
- Edge case: signed 0x80000000 magnitude is 2^31 and fits the unsigned WIDTH path; no overflow handling is needed.
- Downstream muxing of wb_* with other regfile writers is outside this block.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, DONE}
  - default WIDTH
  - register-index constants REG_AX=0, REG_DX=3
- One sub-module, mul_datapath: operand magnitude/sign logic, accumulator/shift register, final negate.
- The top-level keeps the FSM, counter, and handshake outputs.

Test Plan:
- Unsigned 3*5, start at cycle 0 -> busy cycles 1..32; done/wb_sto/wb_mul high only in cycle 33; prod_hi=0x00000000, prod_lo=0x0000000F.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001.
- Signed -3*7 (0xFFFFFFFD, 0x00000007) -> prod_hi=0xFFFFFFFF, prod_lo=0xFFFFFFEB. Signed 0x80000000*0x80000000 -> prod_hi=0x40000000, prod_lo=0x00000000.
- start re-asserted at cycle 10 with different operands -> ignored, first result unchanged. start held in the DONE cycle 33 -> second done in cycle 66 with the second product.
- flush at cycle 15 -> busy 0 from cycle 16, no done pulse, prod outputs keep the prior result.
- rst at cycle 15 -> from cycle 16 all outputs 0, state IDLE, no wb_sto; a new start afterwards completes normally.
